// File: rtl/dct_blk_sched_pkg.sv
// Shared types and widths for the DCT block scheduler and its coefficient FIFO.
package dct_blk_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERST = 2'd1,
        FEED = 2'd2,
        RUN  = 2'd3
    } state_e;

    localparam int SAMP_W    = 15;
    localparam int COEF_W    = 18;
    localparam int IDX_W     = 3;
    localparam int N_PTS_DEF = 16;

    typedef struct packed {
        logic [COEF_W-1:0] coef;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } coef_ent_t;

endpackage

// File: rtl/dct_blk_sched_if.sv
// Sample-in and coefficient-out stream bundle for the DCT block scheduler.
interface dct_blk_sched_if;
    import dct_blk_sched_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [SAMP_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [COEF_W-1:0] m_data;
    logic [IDX_W-1:0]  m_idx;
    logic              m_last;

    modport master (output s_valid, s_data, m_ready,
                    input  s_ready, m_valid, m_data, m_idx, m_last);
    modport slave  (input  s_valid, s_data, m_ready,
                    output s_ready, m_valid, m_data, m_idx, m_last);

endinterface

// File: rtl/dct_coef_fifo.sv
// Synchronous coefficient FIFO with registered head outputs and a free-slot count.
module dct_coef_fifo
    import dct_blk_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  coef_ent_t        push_ent,
    input  logic             pop,
    output logic             head_vld,
    output coef_ent_t        head_ent,
    output logic [CNT_W-1:0] free_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    coef_ent_t        mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    coef_ent_t        head_q, head_d;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop = pop && vld_q;
        rd_d   = do_pop ? ptr_inc(rd_q) : rd_q;
        wr_d   = push ? ptr_inc(wr_q) : wr_q;
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
        vld_d  = (cnt_d != '0);
        head_d = '0;
        // A push into an otherwise empty FIFO becomes the head directly
        if (vld_d) head_d = (push && (wr_q == rd_d)) ? push_ent : mem_q[rd_d];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            head_q <= head_d;
        end
    end

    assign head_vld = vld_q;
    assign head_ent = head_q;
    assign free_cnt = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/dct_blk_sched.sv
// Ping-pong sample buffering and per-block sequencing of the serial DA DCT engine.
module dct_blk_sched
    import dct_blk_sched_pkg::*;
#(
    parameter int N_PTS       = N_PTS_DEF,
    parameter int NUM_COEF    = 4,
    parameter int OUT_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    dct_blk_sched_if.slave    sif,
    output logic              eng_rst,
    output logic [SAMP_W-1:0] eng_in,
    input  logic [COEF_W-1:0] eng_out,
    input  logic              eng_done,
    input  logic [IDX_W-1:0]  eng_k,
    output logic              busy,
    output logic              err_timeout
);
    localparam int CW = $clog2(N_PTS);
    localparam int KW = $clog2(NUM_COEF + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int FW = $clog2(OUT_DEPTH + 1);

    logic [SAMP_W-1:0] bank_q [2][N_PTS];

    state_e            state_q, state_d;
    logic              fill_q, fill_d, next_q, next_d, proc_q, proc_d;
    logic [1:0]        full_q, full_d;
    logic [CW-1:0]     cnt_q, cnt_d, fc_q, fc_d;
    logic [KW-1:0]     coll_q, coll_d;
    logic [TW-1:0]     to_q, to_d;
    logic              err_q, err_d, eng_rst_q, eng_rst_d;
    logic [SAMP_W-1:0] eng_in_q, eng_in_d;

    logic              s_acc, push, rel;
    coef_ent_t         push_ent, head_ent;
    logic              head_vld;
    logic [FW-1:0]     free_cnt;

    assign sif.s_ready = rst && !full_q[fill_q];

    always_comb begin
        s_acc         = sif.s_valid && sif.s_ready;
        // Engine done is unreset, so it only counts while collecting
        push          = (state_q == RUN) && eng_done;
        push_ent.coef = eng_out;
        push_ent.idx  = eng_k;
        push_ent.last = (coll_q == KW'(NUM_COEF - 1));

        state_d = state_q;
        fill_d  = fill_q;
        next_d  = next_q;
        proc_d  = proc_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
        coll_d  = coll_q;
        to_d    = to_q;
        err_d   = err_q;
        rel     = 1'b0;

        if (s_acc) begin
            if (cnt_q == CW'(N_PTS - 1)) begin
                full_d[fill_q] = 1'b1;
                fill_d         = !fill_q;
                cnt_d          = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // next_q walks the banks in fill order, so the older full bank goes first
        case (state_q)
            IDLE: if (full_q[next_q] && (free_cnt >= FW'(NUM_COEF))) begin
                state_d = ERST;
                proc_d  = next_q;
                next_d  = !next_q;
            end
            ERST: begin
                state_d = FEED;
                fc_d    = '0;
            end
            FEED: if (fc_q == CW'(N_PTS - 1)) begin
                state_d = RUN;
                coll_d  = '0;
                to_d    = '0;
            end else begin
                fc_d = fc_q + 1'b1;
            end
            RUN: begin
                to_d = to_q + 1'b1;
                if (push) begin
                    coll_d = coll_q + 1'b1;
                    if (coll_q == KW'(NUM_COEF - 1)) begin
                        rel     = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (!rel && (to_q == TW'(TIMEOUT_CYC - 1))) begin
                    err_d   = 1'b1;
                    rel     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rel) full_d[proc_q] = 1'b0;

        // Engine controls are registered against the next state so they line up with state_q
        eng_rst_d = !((state_d == FEED) || (state_d == RUN));
        eng_in_d  = (state_d == FEED) ? bank_q[proc_q][fc_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (s_acc) bank_q[fill_q][cnt_q] <= sif.s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            fill_q    <= 1'b0;
            next_q    <= 1'b0;
            proc_q    <= 1'b0;
            full_q    <= '0;
            cnt_q     <= '0;
            fc_q      <= '0;
            coll_q    <= '0;
            to_q      <= '0;
            err_q     <= 1'b0;
            eng_rst_q <= 1'b1;
            eng_in_q  <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            next_q    <= next_d;
            proc_q    <= proc_d;
            full_q    <= full_d;
            cnt_q     <= cnt_d;
            fc_q      <= fc_d;
            coll_q    <= coll_d;
            to_q      <= to_d;
            err_q     <= err_d;
            eng_rst_q <= eng_rst_d;
            eng_in_q  <= eng_in_d;
        end
    end

    dct_coef_fifo #(.DEPTH(OUT_DEPTH), .CNT_W(FW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_ent (push_ent),
        .pop      (sif.m_ready),
        .head_vld (head_vld),
        .head_ent (head_ent),
        .free_cnt (free_cnt)
    );

    assign sif.m_valid = head_vld;
    assign sif.m_data  = head_ent.coef;
    assign sif.m_idx   = head_ent.idx;
    assign sif.m_last  = head_ent.last;
    assign eng_rst     = eng_rst_q;
    assign eng_in      = eng_in_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_dct_blk_sched.sv
// Directed bench for dct_blk_sched with a small behavioural engine model.
module tb_dct_blk_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        eng_rst;
    logic [14:0] eng_in;
    logic [17:0] eng_out = '0;
    logic        eng_done = 1'b0;
    logic [2:0]  eng_k = '0;
    logic        busy, err_timeout;

    dct_blk_sched_if sif ();

    dct_blk_sched dut (
        .clk         (clk),
        .rst         (rst),
        .sif         (sif),
        .eng_rst     (eng_rst),
        .eng_in      (eng_in),
        .eng_out     (eng_out),
        .eng_done    (eng_done),
        .eng_k       (eng_k),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Engine model and output monitor state
    logic        spurious = 1'b0;
    logic        eng_en = 1'b1;
    int          ecyc = 0;
    int          last_run = 0;
    int          erst_cnt = 0;
    logic [14:0] feed_log [0:511];
    int          nfeed = 0;
    logic [17:0] out_data [0:127];
    logic [2:0]  out_idx  [0:127];
    logic        out_last [0:127];
    int          nout = 0;
    int          first_stall = -1;

    // Engine: takes 16 samples while out of reset, then pulses done 4 times from RUN cycle 2
    always @(negedge clk) begin
        eng_done = spurious && (eng_rst || (ecyc < 16));
        if (eng_rst) begin
            if (ecyc != 0) last_run = ecyc - 16;
            ecyc = 0;
        end else begin
            if (ecyc < 16) begin
                if (nfeed < 512) feed_log[nfeed] = eng_in;
                nfeed++;
            end else if (eng_en && (ecyc >= 18) && (ecyc < 22)) begin
                eng_done = 1'b1;
                eng_k    = 3'(ecyc - 18);
                eng_out  = 18'h100 + 18'(ecyc - 18);
            end
            ecyc++;
        end
        if (busy && eng_rst) erst_cnt++;
        if (sif.m_valid && sif.m_ready && (nout < 128)) begin
            out_data[nout] = sif.m_data;
            out_idx[nout]  = sif.m_idx;
            out_last[nout] = sif.m_last;
            nout++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int first, input int n);
        int i = 0;
        int g = 0;
        first_stall = -1;
        while (i < n && g < 4000) begin
            sif.s_valid = 1'b1;
            sif.s_data  = 15'(first + i);
            if (sif.s_ready) i++;
            else if (first_stall < 0) first_stall = i;
            tick(1);
            g++;
        end
        sif.s_valid = 1'b0;
        chk("send_all_accepted", 32'(i), 32'(n));
    endtask

    task automatic wait_busy(input logic v, input int maxc, input string tag);
        int c = 0;
        while (busy !== v && c < maxc) begin
            tick(1);
            c++;
        end
        chk(tag, 32'(busy), 32'(v));
    endtask

    task automatic wait_nout(input int target, input int maxc, input string tag);
        int c = 0;
        while (nout < target && c < maxc) begin
            tick(1);
            c++;
        end
        chk(tag, 32'(nout), 32'(target));
    endtask

    // Count entries from ob whose idx/last/data differ from the k=0..3 pattern
    function automatic int out_mism(input int ob, input int n);
        int m = 0;
        for (int j = 0; j < n; j++) begin
            if (out_idx[ob + j] !== 3'(j % 4)) m++;
            if (out_last[ob + j] !== ((j % 4) == 3)) m++;
            if (out_data[ob + j] !== 18'h100 + 18'(j % 4)) m++;
        end
        return m;
    endfunction

    function automatic int feed_mism(input int fb, input int first, input int n);
        int m = 0;
        for (int j = 0; j < n; j++)
            if (feed_log[fb + j] !== 15'(first + j)) m++;
        return m;
    endfunction

    initial begin
        int fb;
        int ob;
        int eb;
        int c;

        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.m_ready = 1'b0;

        // Reset state
        tick(3);
        chk("rst_m_valid", 32'(sif.m_valid), 32'd0);
        chk("rst_m_data", 32'(sif.m_data), 32'd0);
        chk("rst_m_idx", 32'(sif.m_idx), 32'd0);
        chk("rst_m_last", 32'(sif.m_last), 32'd0);
        chk("rst_s_ready", 32'(sif.s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_eng_rst", 32'(eng_rst), 32'd1);
        chk("rst_eng_in", 32'(eng_in), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("s_ready_after_rst", 32'(sif.s_ready), 32'd1);

        // Single block with spurious done during IDLE/ERST/FEED
        spurious = 1'b1;
        fb = nfeed; ob = nout; eb = erst_cnt;
        send(1, 16);
        wait_busy(1'b1, 10, "blk1_start");
        c = 0;
        while (nfeed - fb < 16 && c < 40) begin tick(1); c++; end
        tick(1);
        chk("spur_no_push", 32'(sif.m_valid), 32'd0);
        spurious = 1'b0;
        wait_busy(1'b0, 40, "blk1_done");
        tick(2);
        chk("blk1_erst_cycles", 32'(erst_cnt - eb), 32'd1);
        chk("blk1_run_len", 32'(last_run), 32'd6);
        for (int j = 0; j < 16; j++)
            chk("blk1_eng_in", 32'(feed_log[fb + j]), 32'(j + 1));
        chk("blk1_head_valid", 32'(sif.m_valid), 32'd1);
        chk("blk1_head_data", 32'(sif.m_data), 32'h100);
        chk("blk1_head_idx", 32'(sif.m_idx), 32'd0);
        sif.m_ready = 1'b1;
        wait_nout(ob + 4, 20, "blk1_pops");
        sif.m_ready = 1'b0;
        tick(2);
        chk("blk1_empty", 32'(sif.m_valid), 32'd0);
        for (int j = 0; j < 4; j++) begin
            chk("blk1_out_idx", 32'(out_idx[ob + j]), 32'(j));
            chk("blk1_out_data", 32'(out_data[ob + j]), 32'h100 + 32'(j));
            chk("blk1_out_last", 32'(out_last[ob + j]), 32'(j == 3));
        end

        // Reset mid-FEED with coefficients still queued
        send(201, 16);
        wait_busy(1'b1, 10, "blkA_start");
        wait_busy(1'b0, 60, "blkA_done");
        tick(1);
        chk("blkA_queued", 32'(sif.m_valid), 32'd1);
        send(301, 16);
        c = 0;
        while (eng_rst !== 1'b0 && c < 20) begin tick(1); c++; end
        chk("blkB_feed_start", 32'(eng_rst), 32'd0);
        tick(7);
        rst = 1'b0;
        tick(1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_m_valid", 32'(sif.m_valid), 32'd0);
        chk("midrst_s_ready", 32'(sif.s_ready), 32'd0);
        chk("midrst_eng_rst", 32'(eng_rst), 32'd1);
        rst = 1'b1;
        tick(1);
        fb = nfeed; ob = nout;
        send(401, 16);
        wait_busy(1'b1, 10, "post_rst_start");
        wait_busy(1'b0, 60, "post_rst_done");
        chk("post_rst_feed", 32'(feed_mism(fb, 401, 16)), 32'd0);
        sif.m_ready = 1'b1;
        wait_nout(ob + 4, 20, "post_rst_pops");
        sif.m_ready = 1'b0;
        chk("post_rst_out", 32'(out_mism(ob, 4)), 32'd0);

        // Ping-pong: 48 samples streamed continuously
        tick(2);
        fb = nfeed; ob = nout;
        sif.m_ready = 1'b1;
        send(1, 48);
        chk("pp_first_stall", 32'(first_stall), 32'd32);
        wait_nout(ob + 12, 300, "pp_pops");
        wait_busy(1'b0, 60, "pp_idle");
        sif.m_ready = 1'b0;
        chk("pp_feed_count", 32'(nfeed - fb), 32'd48);
        chk("pp_blk2_first", 32'(feed_log[fb + 16]), 32'd17);
        chk("pp_blk3_first", 32'(feed_log[fb + 32]), 32'd33);
        chk("pp_feed_seq", 32'(feed_mism(fb, 1, 48)), 32'd0);
        chk("pp_out_seq", 32'(out_mism(ob, 12)), 32'd0);

        // Backpressure: FIFO fills with two blocks, third waits for free slots
        tick(2);
        fb = nfeed; ob = nout;
        send(501, 48);
        c = 0;
        while ((nfeed - fb < 32 || busy !== 1'b0) && c < 400) begin tick(1); c++; end
        tick(10);
        chk("bp_third_waits", 32'(busy), 32'd0);
        chk("bp_two_fed", 32'(nfeed - fb), 32'd32);
        chk("bp_fifo_full_valid", 32'(sif.m_valid), 32'd1);
        sif.m_ready = 1'b1;
        tick(3);
        sif.m_ready = 1'b0;
        tick(5);
        chk("bp_hold_after3", 32'(busy), 32'd0);
        sif.m_ready = 1'b1;
        tick(1);
        sif.m_ready = 1'b0;
        tick(3);
        chk("bp_start_after4", 32'(busy), 32'd1);
        wait_busy(1'b0, 60, "bp_third_done");
        chk("bp_blk3_first", 32'(feed_log[fb + 32]), 32'd533);
        sif.m_ready = 1'b1;
        wait_nout(ob + 12, 60, "bp_pops");
        sif.m_ready = 1'b0;
        chk("bp_out_seq", 32'(out_mism(ob, 12)), 32'd0);

        // Timeout: engine never signals done
        tick(2);
        eng_en = 1'b0;
        ob = nout;
        send(601, 16);
        c = 0;
        while (err_timeout !== 1'b1 && c < 1200) begin tick(1); c++; end
        chk("to_err_set", 32'(err_timeout), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        tick(1);
        chk("to_run_len", 32'(last_run), 32'd1024);
        chk("to_no_push", 32'(sif.m_valid), 32'd0);
        eng_en = 1'b1;
        fb = nfeed; ob = nout;
        send(701, 16);
        wait_busy(1'b1, 10, "to_next_start");
        wait_busy(1'b0, 60, "to_next_done");
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
        chk("to_next_feed", 32'(feed_mism(fb, 701, 16)), 32'd0);
        sif.m_ready = 1'b1;
        wait_nout(ob + 4, 20, "to_next_pops");
        sif.m_ready = 1'b0;
        chk("to_next_out", 32'(out_mism(ob, 4)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dct_blk_sched.md
Name: dct_blk_sched

Overview:
- Block scheduler for the serial distributed-arithmetic DCT engine.
- Accepts a valid/ready stream of 15-bit samples and assembles them into 16-sample blocks in a ping-pong buffer.
- Sequences the engine per block: reset pulse, 16-cycle sample feed, then collection of its done-qualified coefficients into an output FIFO.
- Sits between the sample source and the coefficient consumer; the engine is instantiated beside it, not inside it.

Parameters:
- N_PTS, 16, samples per block; fixed by the engine's load phase.
- NUM_COEF, 4, done pulses expected from the engine per block.
- OUT_DEPTH, 8, output FIFO depth; must be >= NUM_COEF.
- TIMEOUT_CYC, 1024, maximum RUN cycles before the block is aborted.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted this cycle when s_valid is also high.
- s_data  in  15  input sample.
- m_valid  out  1  output FIFO not empty.
- m_ready  in  1  consumer pops the FIFO head when m_valid is also high.
- m_data  out  18  coefficient, taken from the engine output.
- m_idx  out  3  coefficient index (engine k at capture).
- m_last  out  1  high on the final coefficient of a block.
- eng_rst  out  1  active-high reset to the engine.
- eng_in  out  15  sample fed to the engine.
- eng_out  in  18  engine coefficient.
- eng_done  in  1  engine one-cycle coefficient-ready pulse.
- eng_k  in  3  engine coefficient index.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (rst==0 at an edge):
  - Engine side: FSM goes to IDLE; eng_rst=1; eng_in=0.
  - Bank state: both banks empty; fill bank=0; fill count=0.
  - Outputs: FIFO emptied (m_valid=0, m_data=0, m_idx=0, m_last=0); s_ready=0; busy=0; err_timeout=0.
  - Reset mid-block discards all buffered samples and coefficients.
- Input side:
  - s_ready=1 when rst is released and the fill bank is not full.
  - Each accepted sample goes to fill_bank[cnt]; cnt increments.
  - When cnt reaches N_PTS, the bank is marked full, the fill pointer toggles and cnt resets to 0.
  - If the other bank is still full or being processed, s_ready=0 until it is released.
- FSM states: IDLE, ERST, FEED, RUN.
- IDLE:
  - eng_rst=1.
  - Goes to ERST when a full bank exists and FIFO free slots >= NUM_COEF. The bank is latched as the proc bank.
- ERST:
  - One cycle with eng_rst=1; next state FEED with feed count=0.
- FEED:
  - eng_rst=0; eng_in=proc_bank[fc]; fc increments each cycle.
  - The engine captures sample fc at the edge ending that cycle.
  - After N_PTS cycles the FSM goes to RUN, with the collected count and the timeout counter at 0.
- RUN:
  - eng_in=0.
  - On each cycle with eng_done==1, {eng_out, eng_k} is pushed into the FIFO and the collected count increments.
  - m_last is tagged on push number NUM_COEF.
  - After the NUM_COEF-th push: the proc bank is released (marked empty), eng_rst=1 and the FSM returns to IDLE.
  - eng_done is ignored outside RUN; the engine's done is unreset, so X/garbage is masked.
- Timeout:
  - If RUN lasts TIMEOUT_CYC cycles without completing, err_timeout is set.
  - Coefficients already pushed stay in the FIFO; m_last is not issued.
  - The proc bank is released and the FSM goes to IDLE.
- FIFO:
  - Overflow is impossible by construction, because of the free-slot check in IDLE.
  - Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
  - Pop on empty is ignored.
  - Head outputs are registered; they reflect the new head on the cycle after a pop.
- Concurrency:
  - The input fill of one bank overlaps FEED/RUN of the other.
  - If the bank being filled completes in the same cycle the proc bank is released, both events apply.
  - Block order is preserved: the older full bank is always scheduled first.
- Minimum block period is 1 + 1 + N_PTS + engine RUN latency cycles. No pipelining of the engine across blocks.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, ERST=1, FEED=2, RUN=3).
  - Width constants: SAMP_W=15, COEF_W=18, IDX_W=3.
  - N_PTS default.
- One sub-module: dct_coef_fifo.
  - Synchronous FIFO, width COEF_W+IDX_W+1, depth OUT_DEPTH.
  - Exposes a free-count output.
  - Same clk/rst conventions.
- Bank storage and FSM stay in the top block.

Test Plan:
- Single block: drive samples 1..16 back-to-back, engine model pulses eng_done 4 times with k=0..3 and eng_out=0x100+k.
  - eng_rst high exactly 1 cycle in ERST.
  - eng_in sequence is 1..16 over 16 consecutive cycles.
  - FIFO delivers 4 entries, idx 0..3, with m_last only on idx 3.
- Ping-pong: stream 48 samples continuously with m_ready=1.
  - s_ready drops only while both banks are full.
  - Three blocks are fed in order: first eng_in of block 2 is sample 17, of block 3 is sample 33.
- Backpressure: m_ready=0 with OUT_DEPTH=8 and 3 blocks queued.
  - Two blocks complete (8 entries); the third stays in IDLE with busy=0.
  - Raising m_ready starts the third block after 4 pops.
- Timeout: engine model never pulses done.
  - After 1024 RUN cycles err_timeout=1 and the FSM is in IDLE.
  - The next block proceeds normally; err_timeout stays 1.
- Reset mid-FEED: drop rst to 0 at FEED cycle 7.
  - The next edge gives IDLE, m_valid=0, s_ready=0, eng_rst=1.
  - After release, a fresh 16 samples produce a correct block.
- Spurious done: eng_done=1 during IDLE/FEED produces no FIFO push; occupancy stays 0.
